// File: rtl/ms_stopwatch_pkg.sv
// Shared types and constants for the millisecond stopwatch core.
package ms_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } state_t;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned MOD_DEC = 10;
  localparam int unsigned MOD_SEX = 6;

endpackage

// File: rtl/ms_stopwatch_digit.sv
// Single BCD digit: modulo-N counter with synchronous clear and carry-out.
module bcd_digit
  import ms_stopwatch_pkg::*;
#(
  parameter int unsigned N = 10
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BCD_W-1:0] q_o,
  output logic             carry_o
);

  logic [BCD_W-1:0] q;
  logic             at_max;

  assign at_max = (q == BCD_W'(N - 1));

  // Wrapping on >= keeps the digit inside its legal range even from a bad value.
  always_ff @(posedge clk_i) begin
    if (clr_i)
      q <= '0;
    else if (inc_i)
      q <= (q >= BCD_W'(N - 1)) ? '0 : q + 1'b1;
  end

  assign q_o     = q;
  assign carry_o = inc_i & at_max;

endmodule

// File: rtl/ms_stopwatch.sv
// Stopwatch core: re-times the 1 kHz wave into ticks, counts BCD MM:SS.hh, run/pause/lap/clear.
module ms_stopwatch
  import ms_stopwatch_pkg::*;
#(
  parameter int unsigned MS_PER_HUND = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ms_clk_i,
  input  logic        start_stop_i,
  input  logic        lap_i,
  input  logic        clear_i,
  output logic [23:0] digits_o,
  output logic        running_o,
  output logic        lap_o,
  output logic        wrap_o
);

  localparam int unsigned PRE_W = (MS_PER_HUND > 1) ? $clog2(MS_PER_HUND) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   tick;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ms_clk_i};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign tick = sync[SYNC_STAGES-1] & ~prev;

  state_t state, state_next;
  logic   latch_en;
  logic   counting;

  assign counting = (state == RUNNING) || (state == LAP);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stop_i) state_next = RUNNING;
        RUNNING: begin
          if (start_stop_i) begin
            state_next = PAUSED;
          end else if (lap_i) begin
            state_next = LAP;
            latch_en   = 1'b1;
          end
        end
        LAP: begin
          if (start_stop_i)
            state_next = PAUSED;
          else if (lap_i)
            state_next = RUNNING;
        end
        PAUSED:  if (start_stop_i) state_next = RUNNING;
        default: state_next = IDLE;
      endcase
    end
  end

  logic [PRE_W-1:0] presc;
  logic             presc_term;
  logic             hund_inc;
  logic             digit_clr;

  assign presc_term = (presc == PRE_W'(MS_PER_HUND - 1));
  assign digit_clr  = reset_i | clear_i;
  // Counting gates on the registered state, so a tick in a transition cycle uses the old state.
  assign hund_inc   = tick & counting & presc_term;

  always_ff @(posedge clk_i) begin
    if (digit_clr)
      presc <= '0;
    else if (tick && counting)
      presc <= presc_term ? '0 : presc + 1'b1;
  end

  logic [BCD_W-1:0] h1, h10, s1, s10, m1, m10;
  logic             c_h1, c_h10, c_s1, c_s10, c_m1, c_m10;
  logic [23:0]      live;
  logic [23:0]      latch;

  bcd_digit #(.N(MOD_DEC)) u_h1  (.clk_i(clk_i), .clr_i(digit_clr), .inc_i(hund_inc), .q_o(h1),  .carry_o(c_h1));
  bcd_digit #(.N(MOD_DEC)) u_h10 (.clk_i(clk_i), .clr_i(digit_clr), .inc_i(c_h1),     .q_o(h10), .carry_o(c_h10));
  bcd_digit #(.N(MOD_DEC)) u_s1  (.clk_i(clk_i), .clr_i(digit_clr), .inc_i(c_h10),    .q_o(s1),  .carry_o(c_s1));
  bcd_digit #(.N(MOD_SEX)) u_s10 (.clk_i(clk_i), .clr_i(digit_clr), .inc_i(c_s1),     .q_o(s10), .carry_o(c_s10));
  bcd_digit #(.N(MOD_DEC)) u_m1  (.clk_i(clk_i), .clr_i(digit_clr), .inc_i(c_s10),    .q_o(m1),  .carry_o(c_m1));
  bcd_digit #(.N(MOD_SEX)) u_m10 (.clk_i(clk_i), .clr_i(digit_clr), .inc_i(c_m1),     .q_o(m10), .carry_o(c_m10));

  assign live = {m10, m1, s10, s1, h10, h1};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      latch     <= '0;
      digits_o  <= '0;
      running_o <= 1'b0;
      lap_o     <= 1'b0;
      wrap_o    <= 1'b0;
    end else begin
      if (clear_i)
        latch <= '0;
      else if (latch_en)
        latch <= live;
      digits_o  <= (state == LAP) ? latch : live;
      running_o <= (state_next == RUNNING) || (state_next == LAP);
      lap_o     <= (state_next == LAP);
      wrap_o    <= c_m10 & ~clear_i;
    end
  end

endmodule
